// File: rtl/mmu_walk_if.sv
// mmu_walk_if: CPU request, memory handshake and translation status bundle for mmu_walk_seq.
// slave is the sequencer's view; master is the CPU/memory side.
interface mmu_walk_if;
    logic        req;
    logic        is_data;
    logic        wr;
    logic        mode;
    logic [31:0] mout;
    logic        mem_ack;
    logic        phase;
    logic        E;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] pte_q;
    logic        busy;
    logic        done;
    logic        pf;
    logic        pf_wp;
    logic        bus_err;

    modport slave (
        input  req, is_data, wr, mode, mout, mem_ack,
        output phase, E, mem_req, mem_we, pte_q, busy, done, pf, pf_wp, bus_err
    );
    modport master (
        output req, is_data, wr, mode, mout, mem_ack,
        input  phase, E, mem_req, mem_we, pte_q, busy, done, pf, pf_wp, bus_err
    );
endinterface

// File: rtl/mmu_walk_seq.sv
// mmu_walk_seq: sequences the PTE read, protection check and access cycle, with page-fault and ack-timeout reporting.
module mmu_walk_seq #(
    parameter int V_BIT   = 11,
    parameter int W_BIT   = 10,
    parameter int TIMEOUT = 16,
    parameter int CW      = 5
) (
    input logic         clk,
    input logic         reset,
    mmu_walk_if.slave   bus
);
    typedef enum logic [2:0] {IDLE, PTE, CHECK, ACCESS, DONE, FAULT, BERR} state_t;

    state_t        state, state_n;
    logic          l_data, l_wr, l_mode, wp_q;
    logic [31:0]   pte_q;
    logic [CW-1:0] cnt;
    logic          tmo;

    assign tmo = cnt == CW'(TIMEOUT - 1);

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (bus.req) state_n = bus.mode ? PTE : ACCESS;
            PTE:     state_n = bus.mem_ack ? CHECK : (tmo ? BERR : PTE);
            CHECK:   state_n = (!pte_q[V_BIT] || (l_data && l_wr && !pte_q[W_BIT])) ? FAULT : ACCESS;
            ACCESS:  state_n = bus.mem_ack ? DONE : (tmo ? BERR : ACCESS);
            default: state_n = IDLE;
        endcase
    end

    // Any state change clears the wait counter, so it starts at zero on entry to PTE and ACCESS.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            l_data <= 1'b0;
            l_wr   <= 1'b0;
            l_mode <= 1'b0;
            wp_q   <= 1'b0;
            pte_q  <= '0;
            cnt    <= '0;
        end else begin
            state <= state_n;
            cnt   <= (state_n != state) ? '0 : cnt + 1'b1;
            if (state == IDLE && bus.req) begin
                l_data <= bus.is_data;
                l_wr   <= bus.wr;
                l_mode <= bus.mode;
            end
            if (state == PTE && bus.mem_ack) pte_q <= bus.mout;
            if (state == CHECK) wp_q <= pte_q[V_BIT];
        end
    end

    assign bus.busy    = state != IDLE;
    assign bus.E       = bus.busy && l_data;
    assign bus.mem_req = state == PTE || state == ACCESS;
    assign bus.phase   = state == ACCESS && l_mode;
    assign bus.mem_we  = state == ACCESS && l_data && l_wr;
    assign bus.pte_q   = pte_q;
    assign bus.done    = state == DONE;
    assign bus.pf      = state == FAULT;
    assign bus.pf_wp   = state == FAULT && wp_q;
    assign bus.bus_err = state == BERR;
endmodule
